exc_seq: RTL

EXC_SEQ -- requirements
Module: exc_seq

---
 rtl/exc_seq_pkg.sv | 41 ++++
 rtl/exc_seq_stage.sv | 57 +++++
 rtl/exc_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/exc_seq_pkg.sv
// exc_seq_pkg
//   Shared definitions for the exception sequencer: MIPS ExcCode values,
//   handler and reset addresses, the FSM state encoding, the per-stage
//   exception record and the oldest-wins merge helper.
package exc_seq_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned PC_W   = 32;

    // ExcCode values (0 doubles as "no exception" inside the pipeline)
    localparam logic [CODE_W-1:0] EXC_INT     = 5'd0;
    localparam logic [CODE_W-1:0] EXC_ADEL    = 5'd4;
    localparam logic [CODE_W-1:0] EXC_ADES    = 5'd5;
    localparam logic [CODE_W-1:0] EXC_SYSCALL = 5'd8;
    localparam logic [CODE_W-1:0] EXC_RI      = 5'd10;
    localparam logic [CODE_W-1:0] EXC_OV      = 5'd12;

    localparam logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [PC_W-1:0] RESET_PC   = 32'h0000_3000;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } exc_state_e;

    // One pipeline stage's exception record
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [PC_W-1:0]   pc;
        logic              bd;
    } stage_t;

    // Oldest exception wins: a nonzero upstream code is never overwritten.
    function automatic logic [CODE_W-1:0] merge_code(
        input logic [CODE_W-1:0] up_code,
        input logic [CODE_W-1:0] local_code
    );
        return (up_code != '0) ? up_code : local_code;
    endfunction

endpackage

// File: rtl/exc_seq_stage.sv
// exc_stage_reg
//   Single pipeline-stage exception register.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     hold_i       : keep current contents (stall on D)
//     bubble_i     : load code 0 with the upstream pc/bd (stall bubble into E)
//     clear_i      : zero the code, keep pc/bd (redirect flush)
//     up_i         : upstream record {code, pc, bd}
//     exc_i        : code detected in this stage
//     q_o          : registered stage record
//   Priority: reset > clear > hold > bubble > normal merge.
module exc_stage_reg
    import exc_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              hold_i,
    input  logic              bubble_i,
    input  logic              clear_i,
    input  stage_t            up_i,
    input  logic [CODE_W-1:0] exc_i,
    output stage_t            q_o
);

    stage_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clear_i) begin
            // pc/bd survive so a later interrupt still reports a defined PC
            q_d.code = '0;
        end else if (hold_i) begin
            q_d = q_q;
        end else if (bubble_i) begin
            q_d.code = '0;
            q_d.pc   = up_i.pc;
            q_d.bd   = up_i.bd;
        end else begin
            q_d.code = merge_code(up_i.code, exc_i);
            q_d.pc   = up_i.pc;
            q_d.bd   = up_i.bd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q.code <= '0;
            q_q.pc   <= RESET_PC;
            q_q.bd   <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/exc_seq.sv
// exc_seq
//   Exception sequencer: carries exception codes down D/E/M alongside the
//   instruction PC and branch-delay flag, presents the M record to CP0, and
//   issues a one-cycle redirect/flush when CP0 takes an exception/interrupt
//   or an eret reaches M.
//   Ports:
//     clk, reset            : clock, synchronous active-high reset
//     stall                 : hazard stall (D holds, bubble into E)
//     f_exc, f_pc, f_bd     : fetch-stage code, PC, delay-slot flag
//     d_exc, e_exc, m_exc   : codes detected in D, E, M
//     eret_m                : eret in M
//     cp0_req, cp0_epc      : CP0 accept (combinational) and EPC
//     cp0_exc, cp0_pc, cp0_bd : merged M record to CP0 (combinational)
//     redirect, redirect_pc : registered PC load strobe and target
//     flush                 : registered F/D flush strobe
module exc_seq
    import exc_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [CODE_W-1:0] f_exc,
    input  logic [PC_W-1:0]   f_pc,
    input  logic              f_bd,
    input  logic [CODE_W-1:0] d_exc,
    input  logic [CODE_W-1:0] e_exc,
    input  logic [CODE_W-1:0] m_exc,
    input  logic              eret_m,
    input  logic              cp0_req,
    input  logic [PC_W-1:0]   cp0_epc,
    output logic [CODE_W-1:0] cp0_exc,
    output logic [PC_W-1:0]   cp0_pc,
    output logic              cp0_bd,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              flush
);

    exc_state_e      state_q, state_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;

    logic   take_exc, take_eret, clear, stall_run;
    stage_t f_rec, d_rec, e_rec, m_rec;

    // ---------------- FSM ----------------
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        take_exc      = 1'b0;
        take_eret     = 1'b0;
        case (state_q)
            ST_RUN: begin
                // cp0_req outranks a simultaneous eret
                if (cp0_req) begin
                    take_exc      = 1'b1;
                    state_d       = ST_REDIRECT;
                    redirect_pc_d = HANDLER_PC;
                end else if (eret_m) begin
                    take_eret     = 1'b1;
                    state_d       = ST_REDIRECT;
                    redirect_pc_d = cp0_epc;
                end
            end
            ST_REDIRECT: state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            redirect_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Codes are zeroed on the redirecting edge and held at zero through the
    // REDIRECT cycle; stall only matters in RUN.
    assign clear     = take_exc || take_eret || (state_q == ST_REDIRECT);
    assign stall_run = stall && (state_q == ST_RUN);

    // ---------------- stage registers ----------------
    assign f_rec.code = f_exc;
    assign f_rec.pc   = f_pc;
    assign f_rec.bd   = f_bd;

    exc_stage_reg u_d (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (stall_run),
        .bubble_i (1'b0),
        .clear_i  (clear),
        .up_i     (f_rec),
        .exc_i    ('0),
        .q_o      (d_rec)
    );

    exc_stage_reg u_e (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (1'b0),
        .bubble_i (stall_run),
        .clear_i  (clear),
        .up_i     (d_rec),
        .exc_i    (d_exc),
        .q_o      (e_rec)
    );

    exc_stage_reg u_m (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (1'b0),
        .bubble_i (1'b0),
        .clear_i  (clear),
        .up_i     (e_rec),
        .exc_i    (e_exc),
        .q_o      (m_rec)
    );

    // ---------------- outputs ----------------
    // Incoming M code is ignored while redirecting so CP0 is not re-triggered.
    assign cp0_exc     = (state_q == ST_REDIRECT) ? '0 : merge_code(m_rec.code, m_exc);
    assign cp0_pc      = m_rec.pc;
    assign cp0_bd      = m_rec.bd;
    assign redirect    = (state_q == ST_REDIRECT);
    assign flush       = (state_q == ST_REDIRECT);
    assign redirect_pc = redirect_pc_q;

endmodule
